vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed-porch VGA sync generator.
- Adds the following, all chosen per parameter:
  - full H/V timing with back porch;
  - programmable sync polarity;
  - pixel clock-enable, so the block runs from the system clock instead of a dedicated 25 MHz clock;
  - line/frame strobes and a frame counter;
  - a configurable output delay that aligns sync with pipelined colour generators.
- Sits between the clock/reset logic and the colour/pattern generators, which consume row, col, vid_on and the strobes.

Parameters:
- HDISP, 640, visible pixels per line
- HFP, 16, horizontal front porch (pixels)
- HPW, 96, hsync pulse width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VDISP, 480, visible lines per frame
- VFP, 10, vertical front porch (lines)
- VPW, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- HPOL, 0, hsync active level (0 = active-low, 1 = active-high)
- VPOL, 0, vsync active level (0 = active-low, 1 = active-high)
- CW, 11, row/col/counter width
- FCW, 8, frame counter width
- PIPE, 0, extra output delay stages (0..4)

Ports:
- clk, in, 1: system clock
- rst, in, 1: reset, asynchronous, active-low
- ce, in, 1: pixel enable; timing advances only on clk edges with ce=1
- hsync, out, 1: horizontal sync, polarity per HPOL
- vsync, out, 1: vertical sync, polarity per VPOL
- vid_on, out, 1: current pixel is in the visible area
- col, out, CW: horizontal pixel index; 0 when vid_on=0
- row, out, CW: vertical line index; 0 when vid_on=0
- line_start, out, 1: one-clk strobe at pixel (0, v) for every v
- frame_start, out, 1: one-clk strobe at pixel (0,0)
- frame_cnt, out, FCW: completed-frame count, wraps modulo 2^FCW

Behaviour:
- Derived constants:
  - HLIM = HDISP+HFP+HPW+HBP; VLIM = VDISP+VFP+VPW+VBP.
  - Elaboration error if HLIM > 2^CW, VLIM > 2^CW, any timing parameter is 0, or PIPE > 4.
- Counters hcount 0..HLIM-1 and vcount 0..VLIM-1 advance only on edges with ce=1.
  - hcount wraps HLIM-1 -> 0; vcount increments on that wrap.
  - vcount wraps VLIM-1 -> 0; frame_cnt increments on that wrap.
- Decode is combinational from the current hcount/vcount:
  - vis = hcount<HDISP && vcount<VDISP.
  - hsync active when HDISP+HFP <= hcount < HDISP+HFP+HPW.
  - vsync active when VDISP+VFP <= vcount < VDISP+VFP+VPW.
- Output stage is registered and loads on ce=1 edges only, capturing the decode of the pre-increment count. Latency is 1 ce-edge; each PIPE stage adds 1 ce-edge. All stages shift only on ce=1.
- Strobes:
  - line_start and frame_start are cleared on any clk edge with ce=0.
  - Each is therefore high for exactly one clk cycle per event, whatever the ce duty.
- All other outputs hold while ce=0.
- frame_cnt travels in the same pipeline as frame_start. It shows the new value in the same cycle frame_start asserts, except for the first frame after reset, where it is 0.
- Reset (rst=0), asynchronous, applied to counters and every pipeline stage:
  - hsync = ~HPOL, vsync = ~VPOL
  - vid_on = 0, row = 0, col = 0
  - line_start = 0, frame_start = 0, frame_cnt = 0
- First ce edge after reset release: the output shows pixel (0,0), so vid_on=1, line_start=1, frame_start=1. With PIPE=n, the reset values persist for n further ce edges.
- Reset mid-frame: outputs go to reset values immediately, not on a clock edge. Timing restarts at (0,0); no partial-line recovery.
- Simultaneous H and V wrap: both counters wrap on the same edge. frame_start and line_start assert together.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants (those above);
  - SYNC_ACT_LOW / SYNC_ACT_HIGH localparams;
  - a small-frame test constant set (6x2 visible).
- One sub-module, vga_delay_line: parametrised width/depth shift register with ce and async active-low reset to a parametrised reset vector. It implements the PIPE stages for the bundle {hsync, vsync, vid_on, row, col, line_start, frame_start, frame_cnt}.

Test Plan:
- Common settings for all scenarios: HDISP=6, HFP=1, HPW=1, HBP=2 (HLIM=10); VDISP=2, VFP=1, VPW=1, VBP=2 (VLIM=6); CW=4, FCW=4, ce=1 unless stated.
- Reset: rst=0 -> hsync=1, vsync=1, vid_on=0, row=col=0, frame_cnt=0. Release on negedge -> first posedge gives col=0, row=0, vid_on=1, frame_start=1, line_start=1.
- Horizontal: vid_on high 6 clks then low 4 clks. hsync low exactly 1 clk, at hcount 7. line_start pulses every 10 clks. col runs 0..5, then 0 when vid_on=0. With HPOL=1, hsync is high for that clk instead.
- Vertical/frame: vsync low for all 10 clks of line 3. frame_start pulses every 60 clks. frame_cnt=1 at clk 60, reaches 15, then wraps to 0 at clk 960.
- ce every other clk: all periods double (line 20 clks, frame 120). Outputs hold on ce=0 clks. line_start and frame_start stay 1 clk wide.
- PIPE=2: output sequence identical to PIPE=0 but delayed 2 ce-edges. Reset values are held for the first 2 ce-edges after release.
- Mid-frame reset: drop rst at hcount=4, vcount=1 between edges -> outputs reach reset values before the next posedge. After release, frame_start=1 at (0,0) and frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults, sync polarity codes and a
// tiny 6x2-visible frame used to exercise the generator quickly.
package vga_timing_pkg;

  localparam int H_DISP = 640;
  localparam int H_FP   = 16;
  localparam int H_PW   = 96;
  localparam int H_BP   = 48;
  localparam int V_DISP = 480;
  localparam int V_FP   = 10;
  localparam int V_PW   = 2;
  localparam int V_BP   = 33;

  localparam int SYNC_ACT_LOW  = 0;
  localparam int SYNC_ACT_HIGH = 1;

  // Small frame: HLIM = 10, VLIM = 6
  localparam int T_HDISP = 6;
  localparam int T_HFP   = 1;
  localparam int T_HPW   = 1;
  localparam int T_HBP   = 2;
  localparam int T_VDISP = 2;
  localparam int T_VFP   = 1;
  localparam int T_VPW   = 1;
  localparam int T_VBP   = 2;
  localparam int T_CW    = 4;
  localparam int T_FCW   = 4;

  // Level a sync line rests at when not asserted.
  function automatic logic sync_idle(input int pol);
    return (pol == SYNC_ACT_HIGH) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of DEPTH stages with async active-low reset
// to a fixed vector; used to align the timing bundle with colour pipelines.
module vga_delay_line #(
  parameter int            W       = 8,
  parameter int            DEPTH   = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else if (ce) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator running off clk with a pixel clock-enable;
// provides row/col, visible flag, line/frame strobes and a frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int HDISP = H_DISP,
  parameter int HFP   = H_FP,
  parameter int HPW   = H_PW,
  parameter int HBP   = H_BP,
  parameter int VDISP = V_DISP,
  parameter int VFP   = V_FP,
  parameter int VPW   = V_PW,
  parameter int VBP   = V_BP,
  parameter int HPOL  = SYNC_ACT_LOW,
  parameter int VPOL  = SYNC_ACT_LOW,
  parameter int CW    = 11,
  parameter int FCW   = 8,
  parameter int PIPE  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           vid_on,
  output logic [CW-1:0]  col,
  output logic [CW-1:0]  row,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int HLIM = HDISP + HFP + HPW + HBP;
  localparam int VLIM = VDISP + VFP + VPW + VBP;

  if (HLIM > 2**CW) begin : g_bad_hlim
    $error("vga_timing_gen: HLIM does not fit in CW bits");
  end
  if (VLIM > 2**CW) begin : g_bad_vlim
    $error("vga_timing_gen: VLIM does not fit in CW bits");
  end
  if (HDISP == 0 || HFP == 0 || HPW == 0 || HBP == 0 ||
      VDISP == 0 || VFP == 0 || VPW == 0 || VBP == 0) begin : g_bad_zero
    $error("vga_timing_gen: timing parameters must be non-zero");
  end
  if (PIPE < 0 || PIPE > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be 0..4");
  end

  localparam logic [CW-1:0] H_END  = CW'(HLIM - 1);
  localparam logic [CW-1:0] V_END  = CW'(VLIM - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(HDISP);
  localparam logic [CW-1:0] V_VIS  = CW'(VDISP);
  localparam logic [CW-1:0] HS_BEG = CW'(HDISP + HFP);
  localparam logic [CW-1:0] HS_END = CW'(HDISP + HFP + HPW);
  localparam logic [CW-1:0] VS_BEG = CW'(VDISP + VFP);
  localparam logic [CW-1:0] VS_END = CW'(VDISP + VFP + VPW);
  localparam logic          HS_IDLE = sync_idle(HPOL);
  localparam logic          VS_IDLE = sync_idle(VPOL);

  localparam int            BW      = 5 + 2*CW + FCW;
  localparam logic [BW-1:0] RST_VEC = {HS_IDLE, VS_IDLE, {(BW-2){1'b0}}};

  logic [CW-1:0]  hcount, vcount;
  logic [FCW-1:0] fcount;
  logic           ce_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= '0;
      vcount <= '0;
      fcount <= '0;
    end else if (ce) begin
      if (hcount == H_END) begin
        hcount <= '0;
        if (vcount == V_END) begin
          vcount <= '0;
          fcount <= fcount + 1'b1;
        end else begin
          vcount <= vcount + 1'b1;
        end
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  logic          vis, hs_d, vs_d, ls_d, fs_d;
  logic [CW-1:0] row_d, col_d;
  logic [BW-1:0] dec, dly;

  always_comb begin
    vis   = (hcount < H_VIS) && (vcount < V_VIS);
    hs_d  = ((hcount >= HS_BEG) && (hcount < HS_END)) ^ HS_IDLE;
    vs_d  = ((vcount >= VS_BEG) && (vcount < VS_END)) ^ VS_IDLE;
    col_d = vis ? hcount : '0;
    row_d = vis ? vcount : '0;
    ls_d  = (hcount == '0);
    fs_d  = (hcount == '0) && (vcount == '0);
    dec   = {hs_d, vs_d, vis, row_d, col_d, ls_d, fs_d, fcount};
  end

  // First stage is the output register; the remaining PIPE stages add delay.
  vga_delay_line #(
    .W       (BW),
    .DEPTH   (PIPE + 1),
    .RST_VAL (RST_VEC)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (dec),
    .q   (dly)
  );

  // Strobes survive only the clk cycle following a ce edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ce_q <= 1'b0;
    else      ce_q <= ce;
  end

  logic ls_q, fs_q;

  assign {hsync, vsync, vid_on, row, col, ls_q, fs_q, frame_cnt} = dly;
  assign line_start  = ls_q & ce_q;
  assign frame_start = fs_q & ce_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on the 10x6 test frame: one PIPE=0
// active-low instance and one PIPE=2 active-high instance share stimulus.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b1;

  logic       hs0, vs0, vid0, ls0, fs0;
  logic [3:0] row0, col0, fc0;
  logic       hs2, vs2, vid2, ls2, fs2;
  logic [3:0] row2, col2, fc2;

  vga_timing_gen #(
    .HDISP(T_HDISP), .HFP(T_HFP), .HPW(T_HPW), .HBP(T_HBP),
    .VDISP(T_VDISP), .VFP(T_VFP), .VPW(T_VPW), .VBP(T_VBP),
    .HPOL(SYNC_ACT_LOW), .VPOL(SYNC_ACT_LOW),
    .CW(T_CW), .FCW(T_FCW), .PIPE(0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(hs0), .vsync(vs0), .vid_on(vid0), .col(col0), .row(row0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .HDISP(T_HDISP), .HFP(T_HFP), .HPW(T_HPW), .HBP(T_HBP),
    .VDISP(T_VDISP), .VFP(T_VFP), .VPW(T_VPW), .VBP(T_VBP),
    .HPOL(SYNC_ACT_HIGH), .VPOL(SYNC_ACT_HIGH),
    .CW(T_CW), .FCW(T_FCW), .PIPE(2)
  ) dut_p2 (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(hs2), .vsync(vs2), .vid_on(vid2), .col(col2), .row(row2),
    .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
  );

  always #5 clk = ~clk;

  logic [16:0] obs0, obs2;
  assign obs0 = {hs0, vs0, vid0, row0, col0, ls0, fs0, fc0};
  assign obs2 = {hs2, vs2, vid2, row2, col2, ls2, fs2, fc2};

  int n_chk  = 0;
  int n_pass = 0;
  int e      = 0;   // ce edges since reset release
  bit last_ce = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected bundle for the idx-th displayed pixel of the 10x6 frame.
  function automatic logic [16:0] exp_vec(input int idx, input bit hp, input bit vp,
                                          input bit ce_edge);
    int h, v, f;
    logic vid, hs, vs, ls, fs;
    logic [3:0] c, r;
    if (idx < 0) return {~hp, ~vp, 15'b0};
    h   = idx % 10;
    v   = (idx / 10) % 6;
    f   = (idx / 60) % 16;
    vid = (h < 6) && (v < 2);
    c   = vid ? 4'(h) : 4'd0;
    r   = vid ? 4'(v) : 4'd0;
    hs  = (h == 7) ? hp : ~hp;
    vs  = (v == 3) ? vp : ~vp;
    ls  = ce_edge && (h == 0);
    fs  = ce_edge && (h == 0) && (v == 0);
    return {hs, vs, vid, r, c, ls, fs, 4'(f)};
  endfunction

  // Called at a negedge: drive ce, take one posedge, check at the next negedge.
  task automatic step(input bit ce_val, input string tag);
    ce = ce_val;
    @(posedge clk);
    if (ce_val) e++;
    last_ce = ce_val;
    @(negedge clk);
    check_val({tag, "_p0"}, 32'(obs0), 32'(exp_vec(e - 1, 1'b0, 1'b0, last_ce)));
    check_val({tag, "_p2"}, 32'(obs2), 32'(exp_vec(e - 3, 1'b1, 1'b1, last_ce)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ce  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e = 0;
    last_ce = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_p0", 32'(obs0), 32'h18000);
    check_val("rst_p2", 32'(obs2), 32'h00000);
    rst = 1'b1;

    // Continuous ce: 16 frames plus a bit, covering frame_cnt wrap
    for (int k = 0; k < 1000; k++) begin
      step(1'b1, "run");
      if (k == 0) begin
        check_val("first_fs",  32'(fs0),  32'd1);
        check_val("first_ls",  32'(ls0),  32'd1);
        check_val("first_vid", 32'(vid0), 32'd1);
        check_val("first_p2",  32'(obs2), 32'h00000);
      end
      if (k == 7)   check_val("hsync_h7", 32'(hs0), 32'd0);
      if (k == 6)   check_val("vid_off_h6", 32'(vid0), 32'd0);
      if (k == 35)  check_val("vsync_l3", 32'(vs0), 32'd0);
      if (k == 9)   check_val("hsync2_h7", 32'(hs2), 32'd1);
      if (k == 60)  check_val("fcnt_60", 32'(fc0), 32'd1);
      if (k == 900) check_val("fcnt_900", 32'(fc0), 32'd15);
      if (k == 960) begin
        check_val("fcnt_960", 32'(fc0), 32'd0);
        check_val("fs_960",   32'(fs0), 32'd1);
      end
    end

    // ce on every other clk: periods double, strobes remain one clk wide
    do_reset();
    for (int n = 0; n < 260; n++) begin
      step((n % 2) == 0, "half");
      if (n == 120) check_val("half_fs120", 32'(fs0), 32'd1);
      if (n == 121) check_val("half_fs121", 32'(fs0), 32'd0);
      if (n == 121) check_val("half_hold",  32'(vid0), 32'd1);
    end

    // Mid-frame reset at hcount=4, vcount=1 after two full frames
    do_reset();
    for (int k = 0; k < 134; k++) step(1'b1, "pre");
    check_val("pre_fcnt", 32'(fc0), 32'd2);
    rst = 1'b0;
    #1;
    check_val("midrst_p0", 32'(obs0), 32'h18000);
    check_val("midrst_p2", 32'(obs2), 32'h00000);
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    last_ce = 1'b0;
    step(1'b1, "post");
    check_val("post_fs",   32'(fs0), 32'd1);
    check_val("post_fcnt", 32'(fc0), 32'd0);
    for (int k = 0; k < 20; k++) step(1'b1, "post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
